// File: rtl/mealy_seq_pkg.sv
// Shared constants and state typedef for the Mealy up/down sequence counter.
package mealy_seq_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 9;
  localparam logic [3:0] ERR_CODE_DEF = 4'hF;
  localparam logic [35:0] DEFAULT_INIT =
    {4'd7, 4'd2, 4'd9, 4'd1, 4'd0, 4'd8, 4'd6, 4'd5, 4'd4};

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_e;
endpackage

// File: rtl/seq_table.sv
// DEPTH x DATA_W code table: synchronous reload from INIT, one write port,
// two combinational read ports.
module seq_table #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 9,
  parameter logic [DEPTH*DATA_W-1:0] INIT = '0,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Addresses at or beyond DEPTH match no entry, so such writes are dropped.
  always_ff @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (Reset) begin
        mem[i] <= INIT[i*DATA_W +: DATA_W];
      end else if (we && (waddr == IDX_W'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == IDX_W'(i)) rdata_a = mem[i];
      if (raddr_b == IDX_W'(i)) rdata_b = mem[i];
    end
  end
endmodule

// File: rtl/mealy_seq_counter.sv
// Up/down sequence counter over a loadable code table; Up&Down traps into ERR.
// bin is the Mealy output: the code of the state being entered this cycle.
module mealy_seq_counter
  import mealy_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter logic [DATA_W-1:0] ERR_CODE = ERR_CODE_DEF,
  parameter bit WRAP = 1'b1,
  parameter logic [DEPTH*DATA_W-1:0] INIT = DEFAULT_INIT,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Up,
  input  logic              Down,
  input  logic              LoadEn,
  input  logic [IDX_W-1:0]  LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
  output logic [DATA_W-1:0] bin,
  output logic [IDX_W-1:0]  idx,
  output logic              error,
  output logic              wrapped
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  state_e            state, nxt_state;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_wrap;
  logic              stepping;
  logic [DATA_W-1:0] rd_cur, rd_nxt;

  seq_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .INIT   (INIT)
  ) u_table (
    .Clock   (Clock),
    .Reset   (Reset),
    .we      (LoadEn),
    .waddr   (LoadAddr),
    .wdata   (LoadData),
    .raddr_a (idx),
    .rdata_a (rd_cur),
    .raddr_b (nxt_idx),
    .rdata_b (rd_nxt)
  );

  // Priority below Reset: LoadEn, Up&Down, ERR exit, Up, Down, hold.
  always_comb begin
    nxt_idx   = idx;
    nxt_state = state;
    nxt_wrap  = 1'b0;
    stepping  = 1'b0;
    if (LoadEn) begin
      nxt_state = state;
    end else if (Up && Down) begin
      nxt_state = ST_ERR;
    end else if (state == ST_ERR) begin
      if (Up ^ Down) begin
        nxt_state = ST_RUN;
        nxt_idx   = '0;
        stepping  = 1'b1;
      end
    end else if (Up) begin
      stepping = 1'b1;
      if (idx == LAST) begin
        nxt_wrap = 1'b1;
        nxt_idx  = WRAP ? '0 : LAST;
      end else begin
        nxt_idx = idx + IDX_W'(1);
      end
    end else if (Down) begin
      stepping = 1'b1;
      if (idx == '0) begin
        nxt_wrap = 1'b1;
        nxt_idx  = WRAP ? LAST : '0;
      end else begin
        nxt_idx = idx - IDX_W'(1);
      end
    end
  end

  // Hold paths read the current entry so they bypass the index arithmetic.
  always_comb begin
    if (Reset)                  bin = INIT[DATA_W-1:0];
    else if (nxt_state == ST_ERR) bin = ERR_CODE;
    else if (stepping)          bin = rd_nxt;
    else                        bin = rd_cur;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx     <= '0;
      state   <= ST_RUN;
      wrapped <= 1'b0;
    end else begin
      idx     <= nxt_idx;
      state   <= nxt_state;
      wrapped <= nxt_wrap;
    end
  end

  assign error = (state == ST_ERR);
endmodule

// File: tb/tb_mealy_seq_counter.sv
// Directed bench for mealy_seq_counter: a wrapping instance and a saturating one
// share all inputs.
module tb_mealy_seq_counter;
  logic       Clock = 1'b0;
  logic       Reset, Up, Down, LoadEn;
  logic [3:0] LoadAddr, LoadData;
  logic [3:0] bin_w, idx_w, bin_s, idx_s;
  logic       error_w, wrapped_w, error_s, wrapped_s;
  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  mealy_seq_counter #(.WRAP(1'b1)) dut (
    .Clock(Clock), .Reset(Reset), .Up(Up), .Down(Down), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData),
    .bin(bin_w), .idx(idx_w), .error(error_w), .wrapped(wrapped_w)
  );

  mealy_seq_counter #(.WRAP(1'b0)) dut_sat (
    .Clock(Clock), .Reset(Reset), .Up(Up), .Down(Down), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData),
    .bin(bin_s), .idx(idx_s), .error(error_s), .wrapped(wrapped_s)
  );

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic drive(input logic u, input logic d, input logic le,
                       input logic [3:0] la, input logic [3:0] ld);
    Up = u; Down = d; LoadEn = le; LoadAddr = la; LoadData = ld;
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 4'd0, 4'd0);
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(0, 0, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd4) begin bad++; $display("FAIL reset_bin_comb got=%0d exp=4", bin_w); end
    tick();
    Reset = 1'b0;
    #1;
    total++; if (idx_w !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx_w); end
    total++; if (error_w !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b exp=0", error_w); end
    total++; if (wrapped_w !== 1'b0) begin bad++; $display("FAIL reset_wrapped got=%0b exp=0", wrapped_w); end
    total++; if (bin_w !== 4'd4) begin bad++; $display("FAIL reset_bin_hold got=%0d exp=4", bin_w); end
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_bin [9] = '{4'd5, 4'd6, 4'd8, 4'd0, 4'd1, 4'd9, 4'd2, 4'd7, 4'd4};
    logic [3:0] exp_idx [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 4'd0, 4'd0);
      total++; if (bin_w !== exp_bin[i]) begin bad++; $display("FAIL up_bin step=%0d got=%0d exp=%0d", i, bin_w, exp_bin[i]); end
      tick();
      total++; if (idx_w !== exp_idx[i]) begin bad++; $display("FAIL up_idx step=%0d got=%0d exp=%0d", i, idx_w, exp_idx[i]); end
      total++; if (wrapped_w !== (i == 8)) begin bad++; $display("FAIL up_wrapped step=%0d got=%0b exp=%0b", i, wrapped_w, (i == 8)); end
    end
    drive(0, 0, 0, 4'd0, 4'd0);
    tick();
    total++; if (wrapped_w !== 1'b0) begin bad++; $display("FAIL up_wrapped_pulse got=%0b exp=0", wrapped_w); end
  endtask

  task automatic test_down_end();
    do_reset();
    drive(0, 1, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd7) begin bad++; $display("FAIL down_wrap_bin got=%0d exp=7", bin_w); end
    total++; if (bin_s !== 4'd4) begin bad++; $display("FAIL down_sat_bin got=%0d exp=4", bin_s); end
    tick();
    total++; if (idx_w !== 4'd8) begin bad++; $display("FAIL down_wrap_idx got=%0d exp=8", idx_w); end
    total++; if (wrapped_w !== 1'b1) begin bad++; $display("FAIL down_wrap_wrapped got=%0b exp=1", wrapped_w); end
    total++; if (idx_s !== 4'd0) begin bad++; $display("FAIL down_sat_idx got=%0d exp=0", idx_s); end
    total++; if (wrapped_s !== 1'b1) begin bad++; $display("FAIL down_sat_wrapped got=%0b exp=1", wrapped_s); end
    // Saturating instance climbs to the top and tries to go past it.
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 4'd0, 4'd0);
      tick();
    end
    total++; if (idx_s !== 4'd8) begin bad++; $display("FAIL sat_climb_idx got=%0d exp=8", idx_s); end
    total++; if (wrapped_s !== 1'b0) begin bad++; $display("FAIL sat_climb_wrapped got=%0b exp=0", wrapped_s); end
    drive(1, 0, 0, 4'd0, 4'd0);
    total++; if (bin_s !== 4'd7) begin bad++; $display("FAIL sat_top_bin got=%0d exp=7", bin_s); end
    tick();
    total++; if (idx_s !== 4'd8) begin bad++; $display("FAIL sat_top_idx got=%0d exp=8", idx_s); end
    total++; if (wrapped_s !== 1'b1) begin bad++; $display("FAIL sat_top_wrapped got=%0b exp=1", wrapped_s); end
  endtask

  task automatic test_error();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4'd0, 4'd0);
      tick();
    end
    total++; if (idx_w !== 4'd3) begin bad++; $display("FAIL err_pre_idx got=%0d exp=3", idx_w); end
    drive(1, 1, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd15) begin bad++; $display("FAIL err_entry_bin got=%0d exp=15", bin_w); end
    tick();
    total++; if (error_w !== 1'b1) begin bad++; $display("FAIL err_entry_error got=%0b exp=1", error_w); end
    total++; if (wrapped_w !== 1'b0) begin bad++; $display("FAIL err_entry_wrapped got=%0b exp=0", wrapped_w); end
    drive(1, 1, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd15) begin bad++; $display("FAIL err_held_bin got=%0d exp=15", bin_w); end
    tick();
    total++; if (error_w !== 1'b1) begin bad++; $display("FAIL err_held_error got=%0b exp=1", error_w); end
    drive(0, 0, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd15) begin bad++; $display("FAIL err_idle_bin got=%0d exp=15", bin_w); end
    tick();
    total++; if (error_w !== 1'b1) begin bad++; $display("FAIL err_idle_error got=%0b exp=1", error_w); end
    drive(0, 1, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd4) begin bad++; $display("FAIL err_exit_bin got=%0d exp=4", bin_w); end
    tick();
    total++; if (idx_w !== 4'd0) begin bad++; $display("FAIL err_exit_idx got=%0d exp=0", idx_w); end
    total++; if (error_w !== 1'b0) begin bad++; $display("FAIL err_exit_error got=%0b exp=0", error_w); end
    total++; if (wrapped_w !== 1'b0) begin bad++; $display("FAIL err_exit_wrapped got=%0b exp=0", wrapped_w); end
  endtask

  task automatic test_load();
    do_reset();
    drive(1, 0, 0, 4'd0, 4'd0);
    tick();
    drive(1, 0, 1, 4'd2, 4'd3);
    total++; if (bin_w !== 4'd5) begin bad++; $display("FAIL load_bin got=%0d exp=5", bin_w); end
    tick();
    total++; if (idx_w !== 4'd1) begin bad++; $display("FAIL load_hold_idx got=%0d exp=1", idx_w); end
    drive(1, 0, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd3) begin bad++; $display("FAIL load_visible_bin got=%0d exp=3", bin_w); end
    tick();
    total++; if (idx_w !== 4'd2) begin bad++; $display("FAIL load_visible_idx got=%0d exp=2", idx_w); end
    drive(0, 0, 1, 4'd12, 4'd0);
    total++; if (bin_w !== 4'd3) begin bad++; $display("FAIL load_oob_bin got=%0d exp=3", bin_w); end
    tick();
    total++; if (idx_w !== 4'd2) begin bad++; $display("FAIL load_oob_idx got=%0d exp=2", idx_w); end
    drive(0, 0, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd3) begin bad++; $display("FAIL load_oob_after_bin got=%0d exp=3", bin_w); end
    drive(1, 0, 0, 4'd0, 4'd0);
    total++; if (bin_w !== 4'd8) begin bad++; $display("FAIL load_oob_next_bin got=%0d exp=8", bin_w); end
    tick();
  endtask

  task automatic test_reset_mid_err();
    logic [3:0] exp_bin [9] = '{4'd5, 4'd6, 4'd8, 4'd0, 4'd1, 4'd9, 4'd2, 4'd7, 4'd4};
    drive(1, 1, 0, 4'd0, 4'd0);
    tick();
    total++; if (error_w !== 1'b1) begin bad++; $display("FAIL rst_err_pre_error got=%0b exp=1", error_w); end
    Reset = 1'b1;
    drive(1, 0, 1, 4'd0, 4'd9);
    total++; if (bin_w !== 4'd4) begin bad++; $display("FAIL rst_err_bin got=%0d exp=4", bin_w); end
    tick();
    Reset = 1'b0;
    drive(0, 0, 0, 4'd0, 4'd0);
    total++; if (idx_w !== 4'd0) begin bad++; $display("FAIL rst_err_idx got=%0d exp=0", idx_w); end
    total++; if (error_w !== 1'b0) begin bad++; $display("FAIL rst_err_error got=%0b exp=0", error_w); end
    total++; if (bin_w !== 4'd4) begin bad++; $display("FAIL rst_err_bin_after got=%0d exp=4", bin_w); end
    // Walk the whole table to confirm the INIT reload and the dropped load.
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 4'd0, 4'd0);
      total++; if (bin_w !== exp_bin[i]) begin bad++; $display("FAIL rst_table step=%0d got=%0d exp=%0d", i, bin_w, exp_bin[i]); end
      tick();
    end
    drive(0, 0, 0, 4'd0, 4'd0);
  endtask

  initial begin
    Reset = 1'b1; Up = 1'b0; Down = 1'b0; LoadEn = 1'b0;
    LoadAddr = 4'd0; LoadData = 4'd0;
    @(negedge Clock);
    test_reset();
    test_up_wrap();
    test_down_end();
    test_error();
    test_load();
    test_reset_mid_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
